// File: rtl/adder_pkg.sv
// Shared constants, slice-width helper and per-stage control record for the pipelined adder.
package adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Control half of the stage record; the operand/partial-sum half is WIDTH-dependent
   // and is declared next to the pipeline that owns it.
   typedef struct packed {
      logic valid;
      logic mode;
      logic carry;
      logic ovf;
   } stage_ctl_t;

endpackage

// File: rtl/add_slice.sv
// Combinational SW-bit ripple-carry slice built from gate-level full adders.
// Latency: none (pure combinational).
// Backpressure: n/a, the enclosing pipeline decides when results are captured.
module add_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout,
   output logic          c_msb
);

   logic carry;

   always_comb begin
      sum   = '0;
      carry = cin;
      c_msb = cin;
      for (int i = 0; i < SW; i++) begin
         c_msb  = carry;
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, one SW-bit slice per clock with registered carries.
// Latency: STAGES cycles from input acceptance to out_valid; one beat per cycle.
// Backpressure: whole pipe holds (bubbles included) when out_valid && !out_ready; in_ready follows.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = slice_w(WIDTH, STAGES);

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
      $error("adder_pipe: WIDTH must be a positive multiple of STAGES");
   end

   typedef struct packed {
      stage_ctl_t       ctl;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] psum;
   } stage_t;

   // st_q[k] holds a beat waiting for slice k; slices below k are already in psum.
   stage_t            st_q [STAGES];
   stage_t            nxt  [STAGES];
   logic [SW-1:0]     slice_sum [STAGES];
   logic [STAGES-1:0] slice_cout;
   logic [STAGES-1:0] slice_ovf;
   logic [WIDTH-1:0]  res;
   logic              advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic [SW-1:0] b_eff;
      logic          c_msb;

      // Mode travels with the beat, so B is inverted slice by slice as it is consumed.
      assign b_eff = (st_q[k].ctl.mode == MODE_SUB) ? ~st_q[k].b_rem[k*SW +: SW]
                                                    :  st_q[k].b_rem[k*SW +: SW];

      add_slice #(.SW(SW)) u_add_slice (
         .a     (st_q[k].a_rem[k*SW +: SW]),
         .b     (b_eff),
         .cin   (st_q[k].ctl.carry),
         .sum   (slice_sum[k]),
         .cout  (slice_cout[k]),
         .c_msb (c_msb)
      );

      assign slice_ovf[k] = slice_cout[k] ^ c_msb;
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         nxt[k] = '0;
      end
      nxt[0].ctl.valid = in_valid;
      nxt[0].ctl.mode  = sub;
      nxt[0].ctl.carry = (sub == MODE_ADD) ? cin : 1'b1;
      nxt[0].a_rem     = a;
      nxt[0].b_rem     = b;
      for (int k = 1; k < STAGES; k++) begin
         nxt[k]                       = st_q[k-1];
         nxt[k].ctl.carry             = slice_cout[k-1];
         nxt[k].ctl.ovf               = slice_ovf[k-1];
         nxt[k].psum[(k-1)*SW +: SW]  = slice_sum[k-1];
      end
      res                          = st_q[STAGES-1].psum;
      res[(STAGES-1)*SW +: SW]     = slice_sum[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= '0;
         end
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= nxt[k];
         end
         out_valid <= st_q[STAGES-1].ctl.valid;
         sum       <= res;
         cout      <= slice_cout[STAGES-1];
         ovf       <= slice_ovf[STAGES-1];
      end
   end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (32-bit, 4 stages): directed vectors, a stalled random stream and reset mid-flight.
module tb_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int checks = 0;
   int errors = 0;
   int n_in   = 0;
   int n_out  = 0;

   logic [33:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [33:0] prev_dat   = '0;

   adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Golden arithmetic: returns {ovf, cout, sum}.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
      logic [31:0] s;
      logic        co;
      logic        ov;
      if (sb) begin
         s  = x - y;
         co = (x >= y);
         ov = (x[31] != y[31]) && (s[31] != x[31]);
      end else begin
         {co, s} = {1'b0, x} + {1'b0, y} + {32'd0, ci};
         ov      = (x[31] == y[31]) && (s[31] != x[31]);
      end
      return {ov, co, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated beat: checks exact latency, literal result, and that the model agrees.
   task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic ci, input logic sb, input logic [31:0] e_sum,
                           input logic e_cout, input logic e_ovf);
      chk({name, "_model"}, {30'd0, model(x, y, ci, sb)}, {30'd0, e_ovf, e_cout, e_sum});
      a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk({name, "_early_valid"}, {63'd0, out_valid}, 64'd0);
      tick();
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({name, "_sum"},   {32'd0, sum},       {32'd0, e_sum});
      chk({name, "_cout"},  {63'd0, cout},      {63'd0, e_cout});
      chk({name, "_ovf"},   {63'd0, ovf},       {63'd0, e_ovf});
      tick();
   endtask

   // Scoreboard: sampled on the falling edge, where handshake signals are settled.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_data", {30'd0, ovf, cout, sum}, {30'd0, prev_dat});
         end
         if (out_valid && out_ready) begin
            chk("out_expected", {63'd0, exp_q.size() > 0}, 64'd1);
            if (exp_q.size() > 0) begin
               chk("stream_result", {30'd0, ovf, cout, sum}, {30'd0, exp_q.pop_front()});
            end
            n_out++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            n_in++;
         end
         prev_stall = out_valid && !out_ready;
         prev_dat   = {ovf, cout, sum};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not terminate");
      $fatal(1);
   end

   initial begin
      int acc;
      int guard;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_sum",       {32'd0, sum},       64'd0);
      chk("reset_cout",      {63'd0, cout},      64'd0);
      chk("reset_ovf",       {63'd0, ovf},       64'd0);
      chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
      rst_n = 1'b1;
      tick();

      directed("add_wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      directed("add_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      directed("sub_borrow",32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      directed("sub_ovf",   32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      directed("add_cin",   32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
      directed("sub_cin_ignored", 32'h9, 32'h9, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0);

      // Random stream with pseudo-random back-pressure and occasional input gaps.
      acc = 0; guard = 0;
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      while (acc < 16 && guard < 2000) begin
         logic took;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         took = in_valid && in_ready;
         tick();
         if (took) begin
            acc++;
            a = $urandom(); b = $urandom();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         end
         guard++;
      end
      chk("stream_accepted", acc, 16);
      in_valid = 1'b0;
      guard = 0;
      while (exp_q.size() > 0 && guard < 300) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end
      out_ready = 1'b1;
      tick(); tick();
      chk("drain_empty", exp_q.size(), 0);
      chk("in_out_count", n_out, n_in);
      chk("no_stray_valid", {63'd0, out_valid}, 64'd0);

      // Three beats in flight, then asynchronous reset.
      a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      a = 32'h3;
      tick();
      a = 32'h4;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", {63'd0, out_valid}, 64'd0);
      chk("async_reset_sum",   {32'd0, sum},       64'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      directed("post_reset", 32'h10, 32'h20, 1'b0, 1'b0, 32'h30, 1'b0, 1'b0);
      tick(); tick(); tick(); tick(); tick();
      chk("post_reset_drained", {63'd0, out_valid}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
